rgb_cmd_arbiter: RTL and testbench
==================================

RGB_CMD_ARBITER -- requirements
Module: rgb_cmd_arbiter

Interface
REQ-001 Parameter GAP, default 4, number of idle HOLD cycles inserted after each issued command (range 0..255).
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 ReqACmd  input  8  requester A (host/UART) command byte.
REQ-005 ReqAValid  input  1  requester A command valid.
REQ-006 ReqAReady  output  1  requester A command accepted this cycle.
REQ-007 ReqBCmd  input  8  requester B (local pattern sequencer) command byte.
REQ-008 ReqBValid  input  1  requester B command valid.
REQ-009 ReqBReady  output  1  requester B command accepted this cycle.
REQ-010 Cmd  output  8  command byte to RGB LED state machine; registered.
REQ-011 NewCmd  output  1  one-cycle strobe qualifying Cmd; registered.
REQ-012 Busy  output  1  high in ISSUE or HOLD.
REQ-013 Dropped  output  1  one-cycle pulse when an illegal byte is consumed.
REQ-014 Shadow  output  3  active-low mirror of LED state (present only with RGB_ARB_SHADOW_EN).

Function
REQ-015 States: IDLE, ISSUE, HOLD; encoding free.
REQ-016 Transfer on requester X occurs when ReqXValid && ReqXReady in the same cycle.
REQ-017 Ready asserted combinationally only in IDLE, only toward the granted requester, never to both in one cycle.
REQ-018 Grant in IDLE: only one valid -> that one; both valid -> the one not granted last (round-robin pointer).
REQ-019 Pointer updates on every transfer, legal or illegal; after reset A wins first tie.
REQ-020 Legal bytes: 82 ('R'), 71 ('G'), 66 ('B'); all others illegal.
REQ-021 Legal transfer in cycle N: Cmd = byte and NewCmd = 1 in cycle N+1 (state ISSUE); NewCmd = 0 in N+2.
REQ-022 ISSUE -> HOLD for exactly GAP cycles -> IDLE; GAP = 0 goes ISSUE -> IDLE directly.
REQ-023 Minimum spacing between NewCmd rising edges is GAP+2 cycles.
REQ-024 Illegal transfer in cycle N: Dropped = 1 in N+1, state stays IDLE, Cmd and NewCmd unchanged/low; next accept possible in N+1.
REQ-025 Cmd holds last legal byte between strobes.
REQ-026 HOLD counter 8 bits, loads GAP on entering HOLD, decrements to 1, exits to IDLE; no wrap.
REQ-027 Valid deasserted without transfer is legal; no request is latched without a transfer.

Reset
REQ-028 While Reset high: state IDLE, ReqAReady = ReqBReady = 0, no transfers.
REQ-029 Cycle after Reset: Cmd = 8'h00, NewCmd = 0, Busy = 0, Dropped = 0, pointer favours A, HOLD counter = 0.
REQ-030 Reset in ISSUE or HOLD aborts the sequence; no further NewCmd for the aborted command.

Configuration
REQ-031 Macro RGB_ARB_SHADOW_EN defined: Shadow port present, reset 3'b111, toggled in the NewCmd cycle (R bit2, G bit1, B bit0).
REQ-032 Macro RGB_ARB_SHADOW_EN undefined: Shadow port and its logic absent; all other behaviour identical.

Verification
REQ-033 Reset, A sends 82 at cycle 10 -> ReqAReady=1 cycle 10, Cmd=82 NewCmd=1 cycle 11 only, Busy 11..15, IDLE cycle 16 (GAP=4).
REQ-034 A and B valid from cycle 10 continuously (71, 66) -> grants A,B,A,B alternate, NewCmd edges 6 cycles apart.
REQ-035 B sends 0x41 -> Dropped=1 next cycle, NewCmd stays 0, B accepted again next cycle with 66 -> NewCmd two cycles after the drop.
REQ-036 GAP=0, A holds 82 valid continuously -> NewCmd every 2nd cycle.
REQ-037 Reset asserted in second HOLD cycle -> Busy=0, NewCmd=0, Ready=0 during reset; next command issues with normal N+1 latency.
REQ-038 RGB_ARB_SHADOW_EN defined, sequence 82,71,82 -> Shadow 111 -> 011 -> 001 -> 101.

Source files
------------

// File: rtl/rgb_cmd_arbiter.sv
// rtl/rgb_cmd_arbiter.sv - two-requester round-robin command arbiter feeding the RGB LED state machine
// Optional feature macro: RGB_ARB_SHADOW_EN adds the active-low Shadow mirror of the LED state.
//
// Requester A (host/UART) and requester B (local pattern sequencer) each offer
// one command byte with a valid/ready handshake. Only 'R', 'G' and 'B' are
// forwarded; any other byte is consumed and flagged on Dropped. Each forwarded
// command is followed by GAP idle HOLD cycles so the LED machine can settle.

module rgb_cmd_arbiter #(
  parameter int GAP = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] ReqACmd,
  input  logic       ReqAValid,
  output logic       ReqAReady,
  input  logic [7:0] ReqBCmd,
  input  logic       ReqBValid,
  output logic       ReqBReady,
  output logic [7:0] Cmd,
  output logic       NewCmd,
  output logic       Busy,
`ifdef RGB_ARB_SHADOW_EN
  output logic [2:0] Shadow,
`endif
  output logic       Dropped
);

  localparam logic [7:0] CMD_R = 8'd82;
  localparam logic [7:0] CMD_G = 8'd71;
  localparam logic [7:0] CMD_B = 8'd66;

  // Hold length as the 8-bit value loaded into the counter.
  localparam logic [7:0] GAP_LOAD = GAP[7:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD
  } state_t;

  state_t     state;
  logic       prefer_b;   // set when A won the last transfer, so B wins the next tie
  logic [7:0] hold_cnt;

  logic       grant_a;
  logic       grant_b;
  logic       xfer;
  logic [7:0] xfer_byte;
  logic       xfer_legal;

  function automatic logic is_legal(input logic [7:0] b);
    return (b == CMD_R) || (b == CMD_G) || (b == CMD_B);
  endfunction

  // Grant selection: only in IDLE and out of reset, single valid wins outright,
  // ties are broken by the round-robin pointer. At most one grant per cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == ST_IDLE && !Reset) begin
      if (ReqAValid && (!ReqBValid || !prefer_b)) begin
        grant_a = 1'b1;
      end else if (ReqBValid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign ReqAReady  = grant_a;
  assign ReqBReady  = grant_b;
  assign xfer       = grant_a | grant_b;
  assign xfer_byte  = grant_a ? ReqACmd : ReqBCmd;
  assign xfer_legal = is_legal(xfer_byte);

  assign Busy = (state != ST_IDLE);

  // Control FSM with registered Cmd/NewCmd/Dropped, round-robin pointer and hold counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_IDLE;
      prefer_b <= 1'b0;
      hold_cnt <= 8'd0;
      Cmd      <= 8'h00;
      NewCmd   <= 1'b0;
      Dropped  <= 1'b0;
    end else begin
      NewCmd  <= 1'b0;
      Dropped <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            // Pointer moves on every transfer, including dropped bytes.
            prefer_b <= grant_a;
            if (xfer_legal) begin
              Cmd    <= xfer_byte;
              NewCmd <= 1'b1;
              state  <= ST_ISSUE;
            end else begin
              // Illegal byte is swallowed; stay in IDLE so the next byte can be taken immediately.
              Dropped <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (GAP_LOAD == 8'd0) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= GAP_LOAD;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Count down to 1 then leave; never let the counter wrap.
          if (hold_cnt <= 8'd1) begin
            hold_cnt <= 8'd0;
            state    <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RGB_ARB_SHADOW_EN
  // Active-low LED mirror: toggle the matching bit in the same edge that raises NewCmd.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Shadow <= 3'b111;
    end else if (state == ST_IDLE && xfer && xfer_legal) begin
      case (xfer_byte)
        CMD_R:   Shadow <= Shadow ^ 3'b100;
        CMD_G:   Shadow <= Shadow ^ 3'b010;
        default: Shadow <= Shadow ^ 3'b001;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rgb_cmd_arbiter.sv
// tb/tb_rgb_cmd_arbiter.sv - self-checking bench for rgb_cmd_arbiter (GAP=4 and GAP=0 instances)

module tb_rgb_cmd_arbiter;

  logic       Clock;
  logic       Reset;
  logic [7:0] ac [2];
  logic       av [2];
  logic       ar [2];
  logic [7:0] bc [2];
  logic       bv [2];
  logic       br [2];
  logic [7:0] cmd [2];
  logic       nc [2];
  logic       busy [2];
  logic       drop [2];
`ifdef RGB_ARB_SHADOW_EN
  logic [2:0] sh [2];
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  rgb_cmd_arbiter #(.GAP(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqACmd(ac[0]), .ReqAValid(av[0]), .ReqAReady(ar[0]),
    .ReqBCmd(bc[0]), .ReqBValid(bv[0]), .ReqBReady(br[0]),
    .Cmd(cmd[0]), .NewCmd(nc[0]), .Busy(busy[0]),
`ifdef RGB_ARB_SHADOW_EN
    .Shadow(sh[0]),
`endif
    .Dropped(drop[0])
  );

  rgb_cmd_arbiter #(.GAP(0)) dut0 (
    .Clock(Clock), .Reset(Reset),
    .ReqACmd(ac[1]), .ReqAValid(av[1]), .ReqAReady(ar[1]),
    .ReqBCmd(bc[1]), .ReqBValid(bv[1]), .ReqBReady(br[1]),
    .Cmd(cmd[1]), .NewCmd(nc[1]), .Busy(busy[1]),
`ifdef RGB_ARB_SHADOW_EN
    .Shadow(sh[1]),
`endif
    .Dropped(drop[1])
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         av;
    logic [7:0] ac;
    bit         bv;
    logic [7:0] bc;
    bit         ar;
    bit         br;
    bit         nc;
    logic [7:0] cmd;
    bit         busy;
    bit         drop;
  } vec_t;

  function automatic vec_t mk(bit rst, bit a_v, int a_c, bit b_v, int b_c,
                              bit e_ar, bit e_br, bit e_nc, int e_cmd, bit e_busy, bit e_drop);
    vec_t v;
    v.rst = rst; v.av = a_v; v.ac = a_c[7:0]; v.bv = b_v; v.bc = b_c[7:0];
    v.ar = e_ar; v.br = e_br; v.nc = e_nc; v.cmd = e_cmd[7:0]; v.busy = e_busy; v.drop = e_drop;
    return v;
  endfunction

  // Behavioural model: a requester is served whenever the arbiter is free;
  // a legal command makes it busy for GAP+1 cycles after the transfer cycle.
  int         m_free [2];
  bit         m_pref_b [2];
  logic [7:0] m_cmd [2];
  bit         m_new [2];
  bit         m_drop [2];
  logic [2:0] m_sh [2];

  task automatic model_reset_state(input int d);
    m_free[d] = 0; m_pref_b[d] = 0; m_cmd[d] = 8'h00;
    m_new[d] = 0; m_drop[d] = 0; m_sh[d] = 3'b111;
  endtask

  task automatic model_cycle(input int d);
    int  gap;
    bit  idle, e_ar, e_br;
    logic [7:0] b;
    gap  = (d == 0) ? 4 : 0;
    idle = (cyc >= m_free[d]);
    e_ar = !Reset && idle && av[d] && (!bv[d] || !m_pref_b[d]);
    e_br = !Reset && idle && bv[d] && (!av[d] || m_pref_b[d]);
    chk($sformatf("rnd%0d_ready_a", d), ar[d], e_ar);
    chk($sformatf("rnd%0d_ready_b", d), br[d], e_br);
    chk($sformatf("rnd%0d_newcmd", d), nc[d], m_new[d]);
    chk($sformatf("rnd%0d_cmd", d), cmd[d], m_cmd[d]);
    chk($sformatf("rnd%0d_busy", d), busy[d], !idle);
    chk($sformatf("rnd%0d_dropped", d), drop[d], m_drop[d]);
`ifdef RGB_ARB_SHADOW_EN
    chk($sformatf("rnd%0d_shadow", d), sh[d], m_sh[d]);
`endif
    if (Reset) begin
      model_reset_state(d);
      m_free[d] = cyc + 1;
    end else begin
      m_new[d]  = 0;
      m_drop[d] = 0;
      if (e_ar || e_br) begin
        b = e_ar ? ac[d] : bc[d];
        m_pref_b[d] = e_ar;
        if (b == 8'd82 || b == 8'd71 || b == 8'd66) begin
          m_cmd[d]  = b;
          m_new[d]  = 1;
          m_free[d] = cyc + gap + 2;
          if (b == 8'd82) m_sh[d][2] = ~m_sh[d][2];
          else if (b == 8'd71) m_sh[d][1] = ~m_sh[d][1];
          else m_sh[d][0] = ~m_sh[d][0];
        end else begin
          m_drop[d] = 1;
        end
      end
    end
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 3))
      0:       return 8'd82;
      1:       return 8'd71;
      2:       return 8'd66;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      av[d] = 0; ac[d] = 0; bv[d] = 0; bc[d] = 0;
    end
  endtask

  // Send one byte on A of the GAP=4 instance from IDLE and return in the last HOLD cycle.
  task automatic send_a(input logic [7:0] b);
    @(negedge Clock); av[0] = 1; ac[0] = b; #1;
    chk("send_ready_a", ar[0], 1);
    @(negedge Clock); av[0] = 0; #1;
    chk("send_newcmd", nc[0], 1);
    chk("send_cmd", cmd[0], b);
    repeat (4) @(negedge Clock);
  endtask

  vec_t tbl[$];
  int   edges[$];
  int   ecmds[$];

  initial begin
    Reset = 1;
    clear_inputs();
    repeat (2) @(negedge Clock);

    // Table: single command, hold window, illegal drop with immediate re-accept, tie after drop.
    tbl.push_back(mk(0, 0,  0, 0,  0,   0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 82, 0,  0,   1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0,  0,   0, 0, 1, 82, 1, 0));
    tbl.push_back(mk(0, 1, 71, 0,  0,   0, 0, 0, 82, 1, 0));
    tbl.push_back(mk(0, 1, 71, 0,  0,   0, 0, 0, 82, 1, 0));
    tbl.push_back(mk(0, 1, 71, 0,  0,   0, 0, 0, 82, 1, 0));
    tbl.push_back(mk(0, 1, 71, 0,  0,   0, 0, 0, 82, 1, 0));
    tbl.push_back(mk(0, 1, 71, 1, 65,   0, 1, 0, 82, 0, 0));
    tbl.push_back(mk(0, 0,  0, 1, 66,   0, 1, 0, 82, 0, 1));
    tbl.push_back(mk(0, 0,  0, 0,  0,   0, 0, 1, 66, 1, 0));
    tbl.push_back(mk(0, 0,  0, 0,  0,   0, 0, 0, 66, 1, 0));
    tbl.push_back(mk(0, 0,  0, 0,  0,   0, 0, 0, 66, 1, 0));
    tbl.push_back(mk(0, 1, 71, 1, 66,   0, 0, 0, 66, 1, 0));
    tbl.push_back(mk(0, 1, 71, 1, 66,   0, 0, 0, 66, 1, 0));
    tbl.push_back(mk(0, 1, 71, 1, 66,   1, 0, 0, 66, 0, 0));
    tbl.push_back(mk(0, 1, 71, 1, 66,   0, 0, 1, 71, 1, 0));
    tbl.push_back(mk(0, 0,  0, 0,  0,   0, 0, 0, 71, 1, 0));
    foreach (tbl[i]) begin
      @(negedge Clock);
      Reset = tbl[i].rst;
      av[0] = tbl[i].av; ac[0] = tbl[i].ac; bv[0] = tbl[i].bv; bc[0] = tbl[i].bc;
      #1;
      cyc = i;
      chk("tbl_ready_a", ar[0], tbl[i].ar);
      chk("tbl_ready_b", br[0], tbl[i].br);
      chk("tbl_newcmd", nc[0], tbl[i].nc);
      chk("tbl_cmd", cmd[0], tbl[i].cmd);
      chk("tbl_busy", busy[0], tbl[i].busy);
      chk("tbl_dropped", drop[0], tbl[i].drop);
    end

    // Continuous A/B contention on GAP=4 alternates grants; GAP=0 with A always valid strobes every 2nd cycle.
    @(negedge Clock); Reset = 1; clear_inputs();
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      Reset = 0;
      av[0] = 1; ac[0] = 8'd71; bv[0] = 1; bc[0] = 8'd66;
      av[1] = 1; ac[1] = 8'd82;
      #1;
      cyc = k;
      chk("never_both_ready", ar[0] & br[0], 0);
      chk("gap0_newcmd", nc[1], k % 2);
      chk("gap0_busy", busy[1], k % 2);
      if (nc[0]) begin
        edges.push_back(k);
        ecmds.push_back(int'(cmd[0]));
      end
    end
    chk("alt_strobe_count", edges.size(), 7);
    if (edges.size() > 0) chk("alt_first_strobe", edges[0], 1);
    foreach (edges[i]) begin
      chk("alt_cmd", ecmds[i], (i % 2 == 0) ? 71 : 66);
      if (i > 0) chk("alt_spacing", edges[i] - edges[i-1], 6);
    end

    // Reset in the second HOLD cycle aborts; next command still issues with one-cycle latency.
    @(negedge Clock); Reset = 1; clear_inputs();
    @(negedge Clock); Reset = 0; av[0] = 1; ac[0] = 8'd82; #1;
    chk("abort_ready_a", ar[0], 1);
    @(negedge Clock); av[0] = 0; #1;
    chk("abort_newcmd", nc[0], 1);
    @(negedge Clock); #1;
    chk("abort_hold1_busy", busy[0], 1);
    @(negedge Clock); Reset = 1; av[0] = 1; ac[0] = 8'd71; #1;
    chk("abort_rst_ready_a", ar[0], 0);
    @(negedge Clock); #1;
    chk("abort_rst_busy", busy[0], 0);
    chk("abort_rst_newcmd", nc[0], 0);
    chk("abort_rst_ready_idle", ar[0], 0);
    chk("abort_rst_cmd", cmd[0], 0);
    @(negedge Clock); Reset = 0; av[0] = 0; #1;
    chk("abort_post_busy", busy[0], 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock); #1;
      chk("abort_no_newcmd", nc[0], 0);
    end
    @(negedge Clock); av[0] = 1; ac[0] = 8'd66; #1;
    chk("abort_next_ready", ar[0], 1);
    @(negedge Clock); av[0] = 0; #1;
    chk("abort_next_newcmd", nc[0], 1);
    chk("abort_next_cmd", cmd[0], 66);
    repeat (5) @(negedge Clock);

`ifdef RGB_ARB_SHADOW_EN
    // Shadow mirror over R, G, R.
    @(negedge Clock); Reset = 1; clear_inputs();
    @(negedge Clock); Reset = 0; #1;
    chk("shadow_reset", sh[0], 3'b111);
    send_a(8'd82);
    chk("shadow_after_r", sh[0], 3'b011);
    send_a(8'd71);
    chk("shadow_after_g", sh[0], 3'b001);
    send_a(8'd82);
    chk("shadow_after_r2", sh[0], 3'b101);
`else
    @(negedge Clock); Reset = 1; clear_inputs();
    @(negedge Clock); Reset = 0;
    send_a(8'd82);
    send_a(8'd71);
`endif

    // Randomized traffic on both instances against the behavioural model.
    @(negedge Clock); Reset = 1; clear_inputs();
    model_reset_state(0);
    model_reset_state(1);
    cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge Clock);
      Reset = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        av[d] = ($urandom_range(0, 2) != 0);
        ac[d] = rand_byte();
        bv[d] = ($urandom_range(0, 2) != 0);
        bc[d] = rand_byte();
      end
      #1;
      cyc = k;
      model_cycle(0);
      model_cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
